// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HALT  = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   localparam int         INST_BYTES = 4;
   localparam logic [1:0] ALIGN_MASK = 2'b00;

endpackage

// File: rtl/fetch_out_stage.sv
// Valid/ready register carrying {pc, inst} from fetch toward decode.
module fetch_out_stage #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              flush,
   input  logic [ADDR_W-1:0] load_pc,
   input  logic [INST_W-1:0] load_inst,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] pc,
   output logic [INST_W-1:0] inst,
   output logic              free
);

   assign free = !valid || ready;

   // Flush beats load; an accepted word with no replacement empties the stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         pc    <= '0;
         inst  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= load_pc;
         inst  <= load_inst;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, handles redirect/halt/end-of-image
// and misaligned-target faults, and counts accepted instructions.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int          ADDR_W    = 64,
   parameter int          INST_W    = 32,
   parameter int          MEM_BYTES = 120,
   parameter logic [63:0] RESET_PC  = 64'd0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_inst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt_req,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst,
   input  logic              if_ready,
   output logic              fetch_done,
   output logic              fault,
   output logic [31:0]       inst_count
);

   // Comparing against the last legal PC avoids the wrap of pc+4 near 2^ADDR_W.
   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - INST_BYTES);
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INST_BYTES);

   fetch_state_t      state, next_state;
   logic [ADDR_W-1:0] pc, next_pc;
   logic              load, flush, free, handshake;

   assign imem_addr  = pc;
   assign handshake  = if_valid && if_ready;
   assign fetch_done = (state == DONE);
   assign fault      = (state == FAULT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
         pc    <= ADDR_W'(RESET_PC);
      end else begin
         state <= next_state;
         pc    <= next_pc;
      end
   end

   // A redirect preempts fetching in every state but FAULT, which is terminal.
   always_comb begin
      next_state = state;
      next_pc    = pc;
      load       = 1'b0;
      flush      = 1'b0;
      if (redirect_valid && state != FAULT) begin
         flush = 1'b1;
         if (redirect_pc[1:0] != ALIGN_MASK) begin
            next_state = FAULT;
         end else begin
            next_pc    = redirect_pc;
            next_state = halt_req ? HALT : FETCH;
         end
      end else begin
         case (state)
            FETCH: begin
               if (halt_req) begin
                  next_state = HALT;
               end else if (free) begin
                  if (pc <= LAST_PC) begin
                     load    = 1'b1;
                     next_pc = pc + STEP;
                  end else begin
                     next_state = DONE;
                  end
               end
            end
            HALT: begin
               if (!halt_req) next_state = FETCH;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inst_count <= '0;
      end else if (handshake && inst_count != 32'hFFFF_FFFF) begin
         inst_count <= inst_count + 32'd1;
      end
   end

   fetch_out_stage #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_out_stage (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .flush     (flush),
      .load_pc   (pc),
      .load_inst (imem_inst),
      .ready     (if_ready),
      .valid     (if_valid),
      .pc        (if_pc),
      .inst      (if_inst),
      .free      (free)
   );

endmodule
